// File: rtl/prt_ingress_writer_if.sv
// Bundle of stream, PRT command and descriptor signals for the PRT ingress writer.
// master = the writer block, slave = its surroundings (stream source, PRT, consumer).
interface prt_ingress_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic                  prt_start_en;
  logic                  prt_start_rdy;
  logic                  prt_start_slot;
  logic                  prt_wr_en;
  logic [DATA_WIDTH-1:0] prt_wr_data;
  logic                  prt_wr_rdy;
  logic                  prt_finish_en;
  logic                  prt_finish_rdy;
  logic                  desc_valid;
  logic                  desc_ready;
  logic                  desc_slot;
  logic [15:0]           desc_len;
  logic                  desc_trunc;
  logic [15:0]           frame_cnt;
  logic [15:0]           trunc_cnt;

  modport master (
    input  s_data, s_valid, s_last, prt_start_rdy, prt_start_slot, prt_wr_rdy,
           prt_finish_rdy, desc_ready,
    output s_ready, prt_start_en, prt_wr_en, prt_wr_data, prt_finish_en,
           desc_valid, desc_slot, desc_len, desc_trunc, frame_cnt, trunc_cnt
  );

  modport slave (
    output s_data, s_valid, s_last, prt_start_rdy, prt_start_slot, prt_wr_rdy,
           prt_finish_rdy, desc_ready,
    input  s_ready, prt_start_en, prt_wr_en, prt_wr_data, prt_finish_en,
           desc_valid, desc_slot, desc_len, desc_trunc, frame_cnt, trunc_cnt
  );
endinterface

// File: rtl/prt_ingress_writer.sv
// Streams framed ingress beats into a PRT slot (start/write/finish) and queues
// one {trunc, slot, len} descriptor per completed frame.
module prt_ingress_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAME  = 2000,
  parameter int DESC_DEPTH = 4
) (
  input logic CLK,
  input logic RST,
  prt_ingress_writer_if.master bus
);
  localparam int          PTR_W   = $clog2(DESC_DEPTH);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DESC_DEPTH);

  typedef enum logic [2:0] {IDLE, START, WAIT_WR, STREAM, FINISH} state_e;
  typedef struct packed {
    logic        trunc;
    logic        slot;
    logic [15:0] len;
  } desc_t;

  state_e           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      trunc_cnt_q, trunc_cnt_d;
  logic             slot_q, slot_d;
  logic             trunc_q, trunc_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  desc_t            fifo_q [DESC_DEPTH];
  desc_t            head;
  logic             push, pop, full, empty;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.desc_ready;
  assign head  = fifo_q[rd_ptr_q];

  // Head fields are gated so stale storage never leaks out while empty/in reset.
  assign bus.desc_valid = !empty;
  assign bus.desc_slot  = !empty && head.slot;
  assign bus.desc_trunc = !empty && head.trunc;
  assign bus.desc_len   = empty ? 16'd0 : head.len;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.trunc_cnt  = trunc_cnt_q;

  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    slot_d            = slot_q;
    trunc_d           = trunc_q;
    frame_cnt_d       = frame_cnt_q;
    trunc_cnt_d       = trunc_cnt_q;
    push              = 1'b0;
    bus.s_ready       = 1'b0;
    bus.prt_start_en  = 1'b0;
    bus.prt_wr_en     = 1'b0;
    bus.prt_wr_data   = '0;
    bus.prt_finish_en = 1'b0;
    case (state_q)
      IDLE: begin
        // Not-full gate guarantees the FINISH push always has room.
        if (bus.s_valid && bus.prt_start_rdy && !full) state_d = START;
      end
      START: begin
        bus.prt_start_en = 1'b1;
        len_d            = '0;
        trunc_d          = 1'b0;
        state_d          = WAIT_WR;
      end
      WAIT_WR: begin
        if (bus.prt_wr_rdy) begin
          slot_d  = bus.prt_start_slot;
          state_d = STREAM;
        end
      end
      STREAM: begin
        bus.s_ready = bus.prt_wr_rdy;
        if (bus.s_valid && bus.prt_wr_rdy) begin
          // Beats past MAX_FRAME are still consumed so the frame drains.
          if (len_q < MAX_LEN) begin
            bus.prt_wr_en   = 1'b1;
            bus.prt_wr_data = bus.s_data;
            len_d           = len_q + 16'd1;
          end else begin
            trunc_d = 1'b1;
          end
          if (bus.s_last) state_d = FINISH;
        end
      end
      FINISH: begin
        bus.prt_finish_en = bus.prt_finish_rdy;
        if (bus.prt_finish_rdy) begin
          push        = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (trunc_q) trunc_cnt_d = trunc_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      len_q       <= '0;
      slot_q      <= 1'b0;
      trunc_q     <= 1'b0;
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      slot_q      <= slot_d;
      trunc_q     <= trunc_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= '{trunc: trunc_q, slot: slot_q, len: len_q};
  end
endmodule

// File: tb/tb_prt_ingress_writer.sv
// Scoreboard bench for prt_ingress_writer: stimulus queues expected writes and
// descriptors, a negedge monitor pops and compares whenever the DUT emits them.
module tb_prt_ingress_writer;
  localparam int DW   = 8;
  localparam int MAXF = 8;
  localparam int DD   = 4;

  typedef struct packed {
    logic        trunc;
    logic        slot;
    logic [15:0] len;
  } exp_desc_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  prt_ingress_writer_if #(.DATA_WIDTH(DW)) bus();
  prt_ingress_writer #(.DATA_WIDTH(DW), .MAX_FRAME(MAXF), .DESC_DEPTH(DD)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  logic [7:0] wq[$];
  exp_desc_t  dq[$];
  int checks = 0, errors = 0;
  int start_cnt = 0, fin_cnt = 0, wr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: PRT command counting, protocol invariants and scoreboard pops.
  always @(negedge CLK) begin
    if (bus.prt_start_en) start_cnt++;
    if (bus.prt_finish_en) fin_cnt++;
    if (int'(bus.prt_start_en) + int'(bus.prt_wr_en) + int'(bus.prt_finish_en) > 1) begin
      errors++;
      $display("FAIL cmd_onehot: more than one PRT command at %0t", $time);
    end
    if (bus.prt_wr_en) begin
      wr_seen++;
      if (!(bus.s_valid && bus.s_ready)) begin
        errors++;
        $display("FAIL wr_without_beat: prt_wr_en with no accepted beat at %0t", $time);
      end
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: data %0h, none expected", bus.prt_wr_data);
      end else check("wr_data", 32'(bus.prt_wr_data), 32'(wq.pop_front()));
    end
    if (bus.desc_valid && bus.desc_ready) begin
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL desc_unexpected: len %0d, none expected", bus.desc_len);
      end else check("desc", 32'({bus.desc_trunc, bus.desc_slot, bus.desc_len}), 32'(dq.pop_front()));
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Drives n beats base, base+1, ...; stalls counts s_ready-low cycles after the first beat.
  task automatic send_beats(input logic [7:0] base, input int n, input bit with_last,
                            input logic slot, output int stalls);
    exp_desc_t e;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = base + 8'(i);
      bus.s_last  = with_last && (i == n - 1);
      if (i < MAXF) wq.push_back(base + 8'(i));
      @(negedge CLK);
      while (!bus.s_ready && t < 100) begin
        if (i > 0) stalls++;
        t++;
        @(negedge CLK);
      end
      if (!bus.s_ready) begin
        errors++;
        $display("FAIL beat_timeout: s_ready 0 expected 1 on beat %0d", i);
        break;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (with_last) begin
      e.trunc = (n > MAXF);
      e.slot  = slot;
      e.len   = 16'((n > MAXF) ? MAXF : n);
      dq.push_back(e);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_cmds"}, 32'({bus.s_ready, bus.prt_start_en, bus.prt_wr_en, bus.prt_finish_en}), 32'd0);
    check({tag, "_wdata"}, 32'(bus.prt_wr_data), 32'd0);
    check({tag, "_desc"}, 32'({bus.desc_valid, bus.desc_trunc, bus.desc_slot, bus.desc_len}), 32'd0);
    check({tag, "_cnts"}, {bus.frame_cnt, bus.trunc_cnt}, 32'd0);
  endtask

  initial begin
    int st, s0, w0, f0, drained;
    bit rdy_seen;
    RST = 1'b1;
    bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0;
    bus.prt_start_rdy = 1; bus.prt_start_slot = 0; bus.prt_wr_rdy = 1;
    bus.prt_finish_rdy = 1; bus.desc_ready = 1;
    repeat (2) @(negedge CLK);
    check_idle_outs("reset");
    tick(); RST = 1'b0;
    tick();

    // 3-beat frame into slot 0
    send_beats(8'hA1, 3, 1'b1, 1'b0, st);
    repeat (3) tick();
    check("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    check("t1_start_fin", {16'(start_cnt), 16'(fin_cnt)}, {16'd1, 16'd1});

    // 10-beat frame truncated at 8, slot 1
    bus.prt_start_slot = 1'b1;
    w0 = wr_seen;
    send_beats(8'h10, 10, 1'b1, 1'b1, st);
    repeat (3) tick();
    check("t2_stalls", 32'(st), 32'd0);
    check("t2_writes", 32'(wr_seen - w0), 32'd8);
    check("t2_trunc_cnt", 32'(bus.trunc_cnt), 32'd1);

    // 6-beat frame with a 4-cycle prt_wr_rdy gap after 3 writes
    bus.prt_start_slot = 1'b0;
    w0 = wr_seen + 3;
    fork
      send_beats(8'h60, 6, 1'b1, 1'b0, st);
      begin
        int t = 0;
        while (wr_seen < w0 && t < 200) begin t++; @(negedge CLK); end
        @(posedge CLK); #1 bus.prt_wr_rdy = 1'b0;
        repeat (4) @(posedge CLK);
        #1 bus.prt_wr_rdy = 1'b1;
      end
    join
    repeat (3) tick();
    check("t3_gap_stalls", 32'(st), 32'd4);
    check("t3_frame_cnt", 32'(bus.frame_cnt), 32'd3);

    // Descriptor FIFO backpressure: four frames fill it, fifth must wait
    bus.desc_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      bus.prt_start_slot = f[0];
      send_beats(8'h80 + 8'(16 * f), 2, 1'b1, f[0], st);
    end
    s0 = start_cnt;
    bus.prt_start_slot = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'hC0;
    rdy_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.s_ready) rdy_seen = 1;
      tick();
    end
    check("t4_blocked_start", 32'(start_cnt - s0), 32'd0);
    check("t4_blocked_ready", 32'(rdy_seen), 32'd0);
    bus.desc_ready = 1'b1; tick(); bus.desc_ready = 1'b0;
    send_beats(8'hC0, 2, 1'b1, 1'b1, st);
    check("t4_fifth_started", 32'(start_cnt - s0), 32'd1);
    bus.desc_ready = 1'b1;  // FSM is in FINISH: push and pop share this cycle
    drained = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.desc_valid) drained++;
    end
    check("t4_drained", 32'(drained), 32'd4);
    tick();
    check("t4_frame_cnt", 32'(bus.frame_cnt), 32'd8);

    // prt_start_rdy low holds the FSM in IDLE
    bus.prt_start_rdy = 1'b0;
    bus.prt_start_slot = 1'b0;
    s0 = start_cnt; w0 = wr_seen; f0 = fin_cnt;
    bus.s_valid = 1'b1; bus.s_data = 8'h50; bus.s_last = 1'b0;
    rdy_seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.s_ready) rdy_seen = 1;
      tick();
    end
    check("t5_no_cmds", {16'(start_cnt - s0), 8'(wr_seen - w0), 8'(fin_cnt - f0)}, 32'd0);
    check("t5_no_ready", 32'(rdy_seen), 32'd0);
    bus.prt_start_rdy = 1'b1;
    tick();
    @(negedge CLK);
    check("t5_start_next", 32'(bus.prt_start_en), 32'd1);
    send_beats(8'h50, 2, 1'b1, 1'b0, st);
    repeat (3) tick();
    check("t5_frame_cnt", 32'(bus.frame_cnt), 32'd9);

    // Reset mid-STREAM after 2 of 5 beats, then a clean frame
    send_beats(8'hD0, 2, 1'b0, 1'b0, st);
    RST = 1'b1;
    @(negedge CLK);
    check_idle_outs("midrst");
    tick(); tick();
    RST = 1'b0;
    bus.prt_start_slot = 1'b1;
    tick();
    send_beats(8'hE0, 3, 1'b1, 1'b1, st);
    repeat (3) tick();
    check("t6_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    check("t6_trunc_cnt", 32'(bus.trunc_cnt), 32'd0);

    check("wq_empty", 32'(wq.size()), 32'd0);
    check("dq_empty", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
